seq_divider: RTL
================

Name: seq_divider

Overview:
- Parametrised multi-cycle integer divider for the CPU execute stage, shared by the DIV/DIVU/REM/REMU paths.
- Radix-2 restoring shift-subtract core: one quotient bit per cycle, fixed latency independent of operand values.
- Valid/ready handshakes on both request and response, plus signed/unsigned mode, divide-by-zero and signed-overflow reporting, and a synchronous flush for pipeline kills.

Parameters:
- N, 16, operand and result width in bits (N >= 4).
- CW, $clog2(N), width of the internal step counter (derived; not to be overridden).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; drops any operation in flight.
- req_valid  in  1  request operands valid.
- req_ready  out  1  divider idle and able to accept a request.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on acceptance.
- dividend  in  N  dividend, sampled on acceptance.
- divisor  in  N  divisor, sampled on acceptance.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- quotient  out  N  quotient.
- remainder  out  N  remainder.
- div_by_zero  out  1  result is from a zero divisor; qualified by rsp_valid.
- overflow  out  1  signed MIN / -1 case; qualified by rsp_valid.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; rsp_valid, quotient, remainder, div_by_zero and overflow are all 0; counter and internal registers are 0. req_ready is 1 after reset release.
- States: IDLE, CALC, DONE.
- req_ready = (state == IDLE) && !flush. It is combinational from state and flush only, never from req_valid.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready.
- IDLE -> DONE on acceptance when divisor == 0:
  - quotient = all ones; remainder = dividend; div_by_zero = 1.
  - Latency 1: rsp_valid is high after the acceptance edge.
- IDLE -> DONE on acceptance when signed_mode && dividend == 2^(N-1) && divisor == all ones:
  - quotient = 2^(N-1); remainder = 0; overflow = 1.
  - Latency 1.
- IDLE -> CALC on any other acceptance:
  - Register the operand magnitudes. In signed mode, negative operands are negated.
  - Register the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)); both are 0 in unsigned mode.
  - Clear the partial remainder and counter.
- CALC step, each edge:
  - Shift the partial remainder left 1 and bring in the dividend MSB.
  - Trial-subtract the divisor magnitude using an N+1-bit subtractor.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- CALC length: exactly N edges. On the N-th edge (counter == N-1), the sign-corrected quotient and remainder are written to the outputs, div_by_zero and overflow are cleared, and the state goes to DONE.
  - Normal latency is N: rsp_valid is high after acceptance edge + N.
- Sign correction: quotient is negated if its sign bit is set. Remainder is negated if the dividend was negative. Truncating division, so the remainder takes the sign of the dividend.
- DONE: rsp_valid = 1. quotient, remainder and flags hold stable until the edge where rsp_valid && rsp_ready, which returns the state to IDLE and clears rsp_valid.
  - No new request is accepted in the DONE cycle; back-to-back throughput is one result per N+2 cycles minimum.
- Outputs change only on the transition into DONE. They hold their previous values in IDLE and CALC and are meaningless while rsp_valid is 0.
- flush: highest synchronous priority. On any edge with flush high:
  - state goes to IDLE, rsp_valid goes to 0, any accepted or pending operation is discarded.
  - A req_valid in that cycle is not accepted, since req_ready is 0.
- rstn asserted mid-CALC or in DONE: immediate return to reset values; no result is produced.
- Operands on dividend and divisor may change freely after acceptance without affecting the result.
- All arithmetic is modulo 2^N on the outputs. Magnitude of 2^(N-1) is represented correctly as an unsigned N-bit value internally.

Test Plan:
- Unsigned, N=16, dividend 100, divisor 7, rsp_ready=1 -> rsp_valid exactly 16 cycles after acceptance; Q=14, R=2, flags 0; req_ready returns 1 the following cycle.
- Signed, dividend 0xFFF9 (-7), divisor 0x0002 -> Q=0xFFFD (-3), R=0xFFFF (-1). Same operands with signed_mode=0 -> Q=0x7FFC, R=0x0001.
- Divide by zero, dividend 0x1234, divisor 0 -> after 1 cycle rsp_valid=1, Q=0xFFFF, R=0x1234, div_by_zero=1, overflow=0.
- Signed overflow, dividend 0x8000, divisor 0xFFFF -> after 1 cycle Q=0x8000, R=0, overflow=1. Same operands unsigned -> latency 16, Q=0, R=0x8000.
- Backpressure: 0xFFFF/0x0010 with rsp_ready low for 5 cycles after rsp_valid -> Q=0x0FFF, R=0x000F held stable, req_ready=0 throughout; request accepted only after the response handshake completes.
- Abort: flush pulsed on cycle 8 of CALC -> no rsp_valid, req_ready=1 next cycle, next request 9/3 -> Q=3, R=0. Repeat with rstn pulsed mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring integer divider (signed/unsigned) with
// valid/ready request and response handshakes, zero-divisor and overflow flags.
module seq_divider #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         signed_mode,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [N-1:0]  MIN_NEG   = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dvd_q, dvd_d;     // dividend magnitude, refilled with quotient bits
    logic [N-1:0]  dvs_q, dvs_d;     // divisor magnitude
    logic [N-1:0]  prem_q, prem_d;   // partial remainder
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;
    logic          rv_q, rv_d;

    logic          a_neg, b_neg;
    logic [N-1:0]  a_mag, b_mag;
    logic [N:0]    rem_shift, diff;
    logic          q_bit;
    logic [N-1:0]  prem_next, quo_next;

    assign req_ready = (state_q == IDLE) && !flush;

    assign rsp_valid   = rv_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    // Operand magnitudes; MIN_NEG negates to itself, which is its correct unsigned magnitude
    assign a_neg = signed_mode & dividend[N-1];
    assign b_neg = signed_mode & divisor[N-1];
    assign a_mag = a_neg ? (N'(0) - dividend) : dividend;
    assign b_mag = b_neg ? (N'(0) - divisor)  : divisor;

    // One restoring step: shift in next dividend bit, trial-subtract on N+1 bits
    assign rem_shift = {prem_q, dvd_q[N-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign q_bit     = ~diff[N];
    assign prem_next = q_bit ? diff[N-1:0] : rem_shift[N-1:0];
    assign quo_next  = {dvd_q[N-2:0], q_bit};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            rv_q    <= rv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        rv_d    = rv_q;

        if (flush) begin
            state_d = IDLE;
            rv_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (divisor == '0) begin
                            quo_d   = '1;
                            rem_d   = dividend;
                            dbz_d   = 1'b1;
                            ovf_d   = 1'b0;
                            rv_d    = 1'b1;
                            state_d = DONE;
                        end else if (signed_mode && (dividend == MIN_NEG) && (divisor == '1)) begin
                            quo_d   = MIN_NEG;
                            rem_d   = '0;
                            dbz_d   = 1'b0;
                            ovf_d   = 1'b1;
                            rv_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            dvd_d   = a_mag;
                            dvs_d   = b_mag;
                            qneg_d  = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            prem_d  = '0;
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    prem_d = prem_next;
                    dvd_d  = quo_next;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        quo_d   = qneg_q ? (N'(0) - quo_next)  : quo_next;
                        rem_d   = rneg_q ? (N'(0) - prem_next) : prem_next;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        rv_d    = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rv_d    = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
